divider_arbiter: RTL and testbench

//  - Shares one sequential 8-bit unsigned divider among N_REQ requesters.
//  - Arbitrates round-robin, latches the winner's operands and pulses div_start.
//  - Waits for div_done, then returns quotient and remainder to the winner only.
//  - Sits between the client blocks and the single divider instance.

---
 rtl/divider_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_divider_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one sequential divider among N_REQ clients.
// Optional WAIT watchdog enabled by defining DIV_ARB_TIMEOUT_EN.
module divider_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_dividend_in,
  input  logic [N_REQ*WIDTH-1:0] i_divisor_in,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]       o_rsp_quotient,
  output logic [WIDTH-1:0]       o_rsp_remainder,
  output logic                   o_rsp_err,
  output logic                   o_busy,
  output logic                   o_div_start,
  output logic [WIDTH-1:0]       o_div_dividend,
  output logic [WIDTH-1:0]       o_div_divisor,
  input  logic                   i_div_done,
  input  logic [WIDTH-1:0]       i_div_quotient,
  input  logic [WIDTH-1:0]       i_div_remainder
);

  localparam int PTR_W = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_bad_params
    $error("divider_arbiter: unsupported parameter set");
  end

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_win;
  logic             r_div_zero;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_quotient;
  logic [WIDTH-1:0] r_rsp_remainder;
  logic             r_rsp_err;
  logic             r_busy;
  logic             r_div_start;
  logic [WIDTH-1:0] r_div_dividend;
  logic [WIDTH-1:0] r_div_divisor;
`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] r_wait_cnt;
`endif

  logic             w_any_req;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W:0]   w_cand;
  logic [N_REQ-1:0] w_win_onehot;
  logic [WIDTH-1:0] w_win_dividend;
  logic [WIDTH-1:0] w_win_divisor;
  logic [PTR_W-1:0] w_next_ptr;

  // Round-robin pick: descending scan so the closest requester at/after r_rr_ptr wins.
  always_comb begin
    w_any_req = 1'b0;
    w_win     = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum  = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
      w_cand = (w_sum >= (PTR_W + 1)'(N_REQ)) ? (w_sum - (PTR_W + 1)'(N_REQ)) : w_sum;
      if (i_req[w_cand[PTR_W-1:0]]) begin
        w_any_req = 1'b1;
        w_win     = w_cand[PTR_W-1:0];
      end else begin
        w_any_req = w_any_req;
      end
    end
  end

  // Operand mux and one-hot decode of the winning requester.
  always_comb begin
    w_win_dividend = '0;
    w_win_divisor  = '0;
    w_win_onehot   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win == PTR_W'(k)) begin
        w_win_dividend  = i_dividend_in[k*WIDTH +: WIDTH];
        w_win_divisor   = i_divisor_in[k*WIDTH +: WIDTH];
        w_win_onehot[k] = 1'b1;
      end else begin
        w_win_onehot[k] = 1'b0;
      end
    end
  end

  assign w_next_ptr = (r_win == PTR_W'(N_REQ - 1)) ? '0 : (r_win + PTR_W'(1));

  // Main FSM: grant/operand capture, divider handshake and response strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_rr_ptr        <= '0;
      r_win           <= '0;
      r_div_zero      <= 1'b0;
      r_gnt           <= '0;
      r_rsp_valid     <= '0;
      r_rsp_quotient  <= '0;
      r_rsp_remainder <= '0;
      r_rsp_err       <= 1'b0;
      r_busy          <= 1'b0;
      r_div_start     <= 1'b0;
      r_div_dividend  <= '0;
      r_div_divisor   <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
      r_wait_cnt      <= '0;
`endif
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_win          <= w_win;
            r_gnt          <= w_win_onehot;
            r_div_dividend <= w_win_dividend;
            r_div_divisor  <= w_win_divisor;
            r_busy         <= 1'b1;
            r_state        <= ST_ISSUE;
            // A zero divisor still occupies the ISSUE slot, but never starts the divider.
            if (w_win_divisor == '0) begin
              r_div_zero      <= 1'b1;
              r_rsp_quotient  <= '1;
              r_rsp_remainder <= w_win_dividend;
            end else begin
              r_div_zero  <= 1'b0;
              r_div_start <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (r_div_zero) begin
            r_rsp_valid <= r_gnt;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_state <= ST_WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (i_div_done) begin
            r_rsp_quotient  <= i_div_quotient;
            r_rsp_remainder <= i_div_remainder;
            r_rsp_valid     <= r_gnt;
            r_rsp_err       <= 1'b0;
            r_state         <= ST_RESP;
          end
`ifdef DIV_ARB_TIMEOUT_EN
          else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_valid     <= r_gnt;
            r_rsp_err       <= 1'b1;
            r_state         <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
`else
          else begin
            r_state <= ST_WAIT;
          end
`endif
        end
        ST_RESP: begin
          r_rsp_valid <= '0;
          r_rsp_err   <= 1'b0;
          r_gnt       <= '0;
          r_busy      <= 1'b0;
          r_rr_ptr    <= w_next_ptr;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt           = r_gnt;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_quotient  = r_rsp_quotient;
  assign o_rsp_remainder = r_rsp_remainder;
  assign o_rsp_err       = r_rsp_err;
  assign o_busy          = r_busy;
  assign o_div_start     = r_div_start;
  assign o_div_dividend  = r_div_dividend;
  assign o_div_divisor   = r_div_divisor;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios and random traffic checked against a
// round-robin / integer-division reference model; the bench also plays the divider.
`timescale 1ns/1ps
module tb_divider_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] dividend_in, divisor_in;
  logic [N-1:0]   gnt, rsp_valid;
  logic [W-1:0]   rsp_q, rsp_r, div_dividend, div_divisor, div_q, div_r;
  logic           rsp_err, busy, div_start, div_done;

  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  int m_ptr = 0;
  int n_pass = 0, n_fail = 0, n_total = 0;

  always #5 clk = ~clk;

  divider_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_dividend_in(dividend_in), .i_divisor_in(divisor_in),
    .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_quotient(rsp_q),
    .o_rsp_remainder(rsp_r), .o_rsp_err(rsp_err), .o_busy(busy),
    .o_div_start(div_start), .o_div_dividend(div_dividend), .o_div_divisor(div_divisor),
    .i_div_done(div_done), .i_div_quotient(div_q), .i_div_remainder(div_r)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int k = 0; k < N; k++) begin
      dividend_in[k*W +: W] = opa[k];
      divisor_in[k*W +: W]  = opb[k];
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_q"}, 32'(rsp_q), 32'd0);
    chk({tag, "_r"}, 32'(rsp_r), 32'd0);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_start"}, 32'(div_start), 32'd0);
    chk({tag, "_dvd"}, 32'(div_dividend), 32'd0);
    chk({tag, "_dvs"}, 32'(div_divisor), 32'd0);
  endtask

  // One full operation from an IDLE cycle through the trailing IDLE cycle.
  task automatic do_op(input int lat, input bit scramble, input bit drop, input logic [N-1:0] raise);
    int w;
    logic [W-1:0] a, b, eq, er;
    logic ee;
    logic [N-1:0] oh;
    w  = pick(req, m_ptr);
    a  = opa[w];
    b  = opb[w];
    oh = N'(1'b1) << w;
    if (b == 8'd0) begin eq = 8'hFF; er = a; ee = 1'b1; end
    else begin eq = a / b; er = a % b; ee = 1'b0; end
    div_done = 1'b1; div_q = 8'h5A; div_r = 8'hA5;   // stray done while IDLE
    step();
    div_done = 1'b0;
    chk("grant", 32'(gnt), 32'(oh));
    chk("busy_op", 32'(busy), 32'd1);
    chk("rsp_idle", 32'(rsp_valid), 32'd0);
    chk("dvd_latch", 32'(div_dividend), 32'(a));
    chk("dvs_latch", 32'(div_divisor), 32'(b));
    chk("start", 32'(div_start), 32'(b != 8'd0));
    if (scramble) begin
      for (int k = 0; k < N; k++) begin
        opa[k] = W'($urandom_range(0, 255));
        opb[k] = W'($urandom_range(0, 255));
      end
      drive_ops();
    end
    if (drop) req[w] = 1'b0;
    if (b != 8'd0) begin
      div_done = 1'b1;                                 // stray done while ISSUE
      step();
      div_done = 1'b0;
      chk("start_pulse", 32'(div_start), 32'd0);
      chk("dvd_stable", 32'(div_dividend), 32'(a));
      req = req | raise;
      repeat (lat - 1) step();
      chk("rsp_wait", 32'(rsp_valid), 32'd0);
      div_done = 1'b1; div_q = eq; div_r = er;
      step();
      div_done = 1'b0; div_q = 8'h33; div_r = 8'hCC;
    end else begin
      step();
      chk("no_start_dz", 32'(div_start), 32'd0);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_q", 32'(rsp_q), 32'(eq));
    chk("rsp_r", 32'(rsp_r), 32'(er));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("gnt_hold", 32'(gnt), 32'(oh));
    req[w] = 1'b0;
    m_ptr  = (w + 1) % N;
    step();
    chk("rsp_single", 32'(rsp_valid), 32'd0);
    chk("gnt_clear", 32'(gnt), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; div_done = 1'b0; div_q = '0; div_r = '0;
    for (int k = 0; k < N; k++) begin opa[k] = '0; opb[k] = '0; end
    drive_ops();
    step(); step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Single request 72/11
    opa[0] = 8'd72; opb[0] = 8'd11; drive_ops();
    req = 4'b0001;
    do_op(7, 1'b0, 1'b0, 4'b0000);

    // Divide by zero 50/0
    opa[2] = 8'd50; opb[2] = 8'd0; drive_ops();
    req = 4'b0100;
    do_op(1, 1'b0, 1'b0, 4'b0000);

    // Round robin with all requests held, pointer reset to 0
    rst_n = 1'b0; step(); rst_n = 1'b1; m_ptr = 0; step();
    opa[0] = 8'd100; opb[0] = 8'd7;
    opa[1] = 8'd200; opb[1] = 8'd13;
    opa[2] = 8'd150; opb[2] = 8'd3;
    opa[3] = 8'd255; opb[3] = 8'd16;
    drive_ops();
    for (int i = 0; i < 5; i++) begin
      req = 4'b1111;
      do_op(i + 2, 1'b0, 1'b0, 4'b0000);
    end

    // Request raised during WAIT stays pending
    req = 4'b0001;
    do_op(5, 1'b0, 1'b0, 4'b0100);
    do_op(3, 1'b0, 1'b0, 4'b0000);

    // Randomized traffic
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] && ($urandom_range(0, 1) == 1)) begin
          req[k] = 1'b1;
          opa[k] = W'($urandom_range(0, 255));
          opb[k] = ($urandom_range(0, 5) == 0) ? 8'd0 : W'($urandom_range(1, 255));
        end
      end
      drive_ops();
      if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
      do_op($urandom_range(1, 9), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 4'b0000);
    end

    // Reset in WAIT, then a late div_done
    req = '0; step();
    opa[1] = 8'd99; opb[1] = 8'd9; drive_ops();
    req = 4'b0010;
    step();
    chk("mid_grant", 32'(gnt), 32'b0010);
    step(); step();
    rst_n = 1'b0; req = '0;
    step();
    rst_n = 1'b1;
    chk_all_zero("mid_reset");
    div_done = 1'b1; div_q = 8'd11; div_r = 8'd0;
    step();
    div_done = 1'b0;
    chk("late_done_rsp", 32'(rsp_valid), 32'd0);
    chk("late_done_busy", 32'(busy), 32'd0);
    step();
    chk("late_done_rsp2", 32'(rsp_valid), 32'd0);
    m_ptr = 0;

`ifdef DIV_ARB_TIMEOUT_EN
    // Watchdog: no div_done, response exactly 32 cycles after entering WAIT
    opa[3] = 8'd77; opb[3] = 8'd5; drive_ops();
    req = 4'b1000;
    step();
    chk("to_grant", 32'(gnt), 32'b1000);
    step();
    repeat (31) step();
    chk("to_early", 32'(rsp_valid), 32'd0);
    step();
    chk("to_valid", 32'(rsp_valid), 32'b1000);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_q", 32'(rsp_q), 32'd0);
    chk("to_r", 32'(rsp_r), 32'd0);
    req = '0; m_ptr = 0;
    step();
    div_done = 1'b1;
    step();
    div_done = 1'b0;
    chk("to_late_done", 32'(rsp_valid), 32'd0);
    opa[0] = 8'd40; opb[0] = 8'd6; drive_ops();
    req = 4'b0001;
    do_op(2, 1'b0, 1'b0, 4'b0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
